eigenloop_multi: RTL and testbench

- Parametrised power-iteration sequencer: extracts NUM_COMP dominant eigenvectors in turn.
- For each component it repeatedly launches the external recursion unit (v' = A·v, normalised) and the convergence checker until the checker passes or MAX_ITER is reached.
- Between components it launches an external deflation unit.
- Sits between the whitening/covariance stage and the separation stage of the fetal-ECG pipeline, replacing the single-vector loop controller.

---
 rtl/eigenloop_multi.sv | 172 +++++++++++++++++
 tb/tb_eigenloop_multi.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/eigenloop_multi.sv
// eigenloop_multi: power-iteration sequencer that extracts NUM_COMP dominant
// eigenvectors one after another.
//
// For each component it loops: launch the recursion unit (v' = A*v, normalised),
// then launch the convergence checker on (v_k, v_{k+1}). The loop ends when the
// checker passes or MAX_ITER recursions have been done. The result is then
// emitted. Between components the deflation unit is launched and the loop
// restarts from the captured starting vector.
//
// Ports:
//   clk, rst          clock, asynchronous active-high reset
//   start, abort      run control (start accepted only in IDLE/DONE; abort wins)
//   init_vec          starting vector, element i at [i*DW +: DW]
//   rec_*             recursion unit handshake (start pulse, vector, done/result)
//   conv_*            convergence checker handshake (start, prev/next, done/ok)
//   defl_*            deflation unit handshake (start, vector, done)
//   vec_out/vec_valid emitted eigenvector and its one-cycle strobe
//   comp_idx          component in progress / just emitted
//   iter_count        recursions completed for the current component
//   timeout           sticky per run: a component hit MAX_ITER unconverged
//   busy, done        status
module eigenloop_multi #(
  parameter int SIZE_N   = 8,
  parameter int DW       = 64,
  parameter int MAX_ITER = 100,
  parameter int NUM_COMP = 2,
  parameter int KW       = $clog2(MAX_ITER + 1),
  parameter int CW       = (NUM_COMP > 1) ? $clog2(NUM_COMP) : 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic                 abort,
  input  logic [SIZE_N*DW-1:0] init_vec,
  output logic                 rec_start,
  output logic [SIZE_N*DW-1:0] rec_vec,
  input  logic                 rec_done,
  input  logic [SIZE_N*DW-1:0] rec_result,
  output logic                 conv_start,
  output logic [SIZE_N*DW-1:0] conv_prev,
  output logic [SIZE_N*DW-1:0] conv_next,
  input  logic                 conv_done,
  input  logic                 conv_ok,
  output logic                 defl_start,
  output logic [SIZE_N*DW-1:0] defl_vec,
  input  logic                 defl_done,
  output logic [SIZE_N*DW-1:0] vec_out,
  output logic                 vec_valid,
  output logic [CW-1:0]        comp_idx,
  output logic [KW-1:0]        iter_count,
  output logic                 timeout,
  output logic                 busy,
  output logic                 done
);

  localparam int VW = SIZE_N * DW;

  typedef enum logic [3:0] {
    S_IDLE, S_REC, S_REC_WAIT, S_CONV, S_CONV_WAIT,
    S_EMIT, S_DEFL, S_DEFL_WAIT, S_DONE
  } state_t;

  state_t state, state_nxt;

  logic [VW-1:0] vinit;
  logic [VW-1:0] vcur;
  logic [VW-1:0] vnxt;

  logic iter_max;
  logic last_comp;

  assign iter_max  = (iter_count == KW'(MAX_ITER));
  assign last_comp = (comp_idx == CW'(NUM_COMP - 1));

  assign rec_vec   = vcur;
  assign conv_prev = vcur;
  assign conv_next = vnxt;
  assign defl_vec  = vnxt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nxt;
  end

  // Launch pulses are decoded from the state but suppressed by abort, so an
  // aborted cycle never leaks a launch to an external unit.
  always_comb begin
    state_nxt  = state;
    rec_start  = 1'b0;
    conv_start = 1'b0;
    defl_start = 1'b0;
    busy       = 1'b0;
    done       = 1'b0;
    if (abort) begin
      state_nxt = S_IDLE;
    end else begin
      case (state)
        S_IDLE, S_DONE: if (start) state_nxt = S_REC;
        S_REC:          state_nxt = S_REC_WAIT;
        S_REC_WAIT:     if (rec_done) state_nxt = S_CONV;
        S_CONV:         state_nxt = S_CONV_WAIT;
        S_CONV_WAIT: begin
          if (conv_done) state_nxt = (conv_ok || iter_max) ? S_EMIT : S_REC;
        end
        S_EMIT:         state_nxt = last_comp ? S_DONE : S_DEFL;
        S_DEFL:         state_nxt = S_DEFL_WAIT;
        S_DEFL_WAIT:    if (defl_done) state_nxt = S_REC;
        default:        state_nxt = S_IDLE;
      endcase
      rec_start  = (state == S_REC);
      conv_start = (state == S_CONV);
      defl_start = (state == S_DEFL);
    end
    busy = (state != S_IDLE) && (state != S_DONE);
    done = (state == S_DONE);
  end

  // Vector and counter registers. vec_valid is registered together with
  // vec_out so the strobe and the emitted vector appear in the same cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vinit      <= '0;
      vcur       <= '0;
      vnxt       <= '0;
      vec_out    <= '0;
      vec_valid  <= 1'b0;
      comp_idx   <= '0;
      iter_count <= '0;
      timeout    <= 1'b0;
    end else begin
      vec_valid <= 1'b0;
      if (!abort) begin
        case (state)
          S_IDLE, S_DONE: begin
            if (start) begin
              vinit      <= init_vec;
              vcur       <= init_vec;
              comp_idx   <= '0;
              iter_count <= '0;
              timeout    <= 1'b0;
            end
          end
          S_REC_WAIT: begin
            if (rec_done) begin
              vnxt <= rec_result;
              if (!iter_max) iter_count <= iter_count + KW'(1);
            end
          end
          S_CONV_WAIT: begin
            if (conv_done && !conv_ok) begin
              if (iter_max) timeout <= 1'b1;
              else          vcur    <= vnxt;
            end
          end
          S_EMIT: begin
            vec_out   <= vnxt;
            vec_valid <= 1'b1;
          end
          S_DEFL_WAIT: begin
            if (defl_done) begin
              comp_idx   <= comp_idx + CW'(1);
              iter_count <= '0;
              vcur       <= vinit;
            end
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_eigenloop_multi.sv
// Testbench for eigenloop_multi: the bench plays the recursion, convergence and
// deflation units with random results, random convergence decisions and random
// latencies, and checks every handshake against a transaction-level model of
// the power-iteration sequence.
module tb_eigenloop_multi;

  localparam int SN = 4;
  localparam int DWT = 16;
  localparam int MI = 4;
  localparam int NC = 3;
  localparam int KWT = $clog2(MI + 1);
  localparam int CWT = 2;
  localparam int VW = SN * DWT;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic start = 1'b0, abort = 1'b0;
  logic [VW-1:0] init_vec = '0;
  logic rec_start, conv_start, defl_start;
  logic [VW-1:0] rec_vec, conv_prev, conv_next, defl_vec, vec_out;
  logic rec_done = 1'b0, conv_done = 1'b0, conv_ok = 1'b0, defl_done = 1'b0;
  logic [VW-1:0] rec_result = '0;
  logic vec_valid, timeout, busy, done;
  logic [CWT-1:0] comp_idx;
  logic [KWT-1:0] iter_count;

  eigenloop_multi #(.SIZE_N(SN), .DW(DWT), .MAX_ITER(MI), .NUM_COMP(NC)) dut (
    .clk(clk), .rst(rst), .start(start), .abort(abort), .init_vec(init_vec),
    .rec_start(rec_start), .rec_vec(rec_vec), .rec_done(rec_done),
    .rec_result(rec_result), .conv_start(conv_start), .conv_prev(conv_prev),
    .conv_next(conv_next), .conv_done(conv_done), .conv_ok(conv_ok),
    .defl_start(defl_start), .defl_vec(defl_vec), .defl_done(defl_done),
    .vec_out(vec_out), .vec_valid(vec_valid), .comp_idx(comp_idx),
    .iter_count(iter_count), .timeout(timeout), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  int n_rec = 0, n_conv = 0, n_defl = 0, n_vv = 0;
  always @(posedge clk) begin
    if (rec_start)  n_rec  <= n_rec + 1;
    if (conv_start) n_conv <= n_conv + 1;
    if (defl_start) n_defl <= n_defl + 1;
    if (vec_valid)  n_vv   <= n_vv + 1;
  end

  int n_chk = 0;
  int n_pass = 0;
  logic [VW-1:0] exp_vout = '0;

  task automatic chk(input string tag, input logic [VW-1:0] got, input logic [VW-1:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  function automatic logic sig(input int sel);
    case (sel)
      0: return rec_start;
      1: return conv_start;
      2: return defl_start;
      3: return vec_valid;
      default: return done;
    endcase
  endfunction

  task automatic wait_pulse(input string tag, input int sel);
    int n = 0;
    while (!sig(sel) && n < 40) begin
      @(negedge clk);
      n++;
    end
    chk({tag, " seen"}, VW'(sig(sel)), VW'(1));
  endtask

  // mode: 0 normal, 1 start-while-busy + spurious defl_done, 2 abort in the
  // second CONV_WAIT, 3 reset in the first DEFL_WAIT.
  // okmode: 0 random, 1 never converge, 2 converge on second check.
  task automatic run(input int mode, input int okmode);
    logic [VW-1:0] init, vcur_m, last;
    logic [VW-1:0] res [NC][MI];
    bit ok [NC][MI];
    int k, exp_rec, b_rec, b_vv, b_defl;
    bit tmo;
    init = {$urandom, $urandom};
    exp_rec = 0;
    for (int c = 0; c < NC; c++) begin
      k = MI;
      for (int j = 0; j < MI; j++) begin
        res[c][j] = {$urandom, $urandom};
        ok[c][j] = (okmode == 1) ? 1'b0 : (okmode == 2) ? (j == 1) : ($urandom_range(0, 3) == 0);
      end
      for (int j = MI - 1; j >= 0; j--) if (ok[c][j]) k = j + 1;
      exp_rec += k;
    end
    b_rec = n_rec; b_vv = n_vv; b_defl = n_defl;
    tmo = 1'b0;
    last = '0;
    init_vec = init; start = 1'b1;
    @(negedge clk);
    start = 1'b0; init_vec = {$urandom, $urandom};
    for (int c = 0; c < NC; c++) begin
      vcur_m = init;
      k = 0;
      for (int j = 0; j < MI; j++) begin
        wait_pulse("rec_start", 0);
        chk("rec_vec", rec_vec, vcur_m);
        chk("iter_count_at_launch", VW'(iter_count), VW'(j));
        @(negedge clk);
        if (mode == 1 && c == 0 && j == 0) begin
          start = 1'b1; defl_done = 1'b1; init_vec = ~init;
          @(negedge clk);
          start = 1'b0; defl_done = 1'b0;
          chk("busy_after_spurious", VW'(busy), VW'(1));
        end
        repeat ($urandom_range(0, 2)) @(negedge clk);
        rec_done = 1'b1; rec_result = res[c][j];
        @(negedge clk);
        rec_done = 1'b0; rec_result = {$urandom, $urandom};
        wait_pulse("conv_start", 1);
        chk("conv_prev", conv_prev, vcur_m);
        chk("conv_next", conv_next, res[c][j]);
        chk("iter_count_after_rec", VW'(iter_count), VW'(j + 1));
        @(negedge clk);
        if (mode == 2 && c == 0 && j == 1) begin
          abort = 1'b1;
          @(negedge clk);
          abort = 1'b0;
          chk("abort_busy", VW'(busy), VW'(0));
          chk("abort_done", VW'(done), VW'(0));
          chk("abort_vec_out", vec_out, exp_vout);
          chk("abort_timeout", VW'(timeout), VW'(0));
          conv_done = 1'b1; conv_ok = 1'b1;
          @(negedge clk);
          conv_done = 1'b0; conv_ok = 1'b0;
          repeat (3) @(negedge clk);
          chk("abort_idle_busy", VW'(busy), VW'(0));
          chk("abort_rec_count", VW'(n_rec - b_rec), VW'(2));
          chk("abort_no_vec_valid", VW'(n_vv - b_vv), VW'(0));
          return;
        end
        repeat ($urandom_range(0, 2)) @(negedge clk);
        conv_done = 1'b1; conv_ok = ok[c][j];
        @(negedge clk);
        conv_done = 1'b0; conv_ok = 1'($urandom);
        last = res[c][j];
        k = j + 1;
        if (ok[c][j]) break;
        if (j == MI - 1) tmo = 1'b1;
        vcur_m = res[c][j];
      end
      wait_pulse("vec_valid", 3);
      chk("vec_out", vec_out, last);
      chk("comp_idx", VW'(comp_idx), VW'(c));
      chk("iter_count_emit", VW'(iter_count), VW'(k));
      chk("timeout", VW'(timeout), VW'(tmo));
      exp_vout = last;
      if (c < NC - 1) begin
        wait_pulse("defl_start", 2);
        chk("defl_vec", defl_vec, last);
        @(negedge clk);
        if (mode == 3) begin
          #2 rst = 1'b1;
          #1;
          exp_vout = '0;
          chk("rst_busy", VW'(busy), VW'(0));
          chk("rst_vec_out", vec_out, exp_vout);
          chk("rst_timeout", VW'(timeout), VW'(0));
          chk("rst_iter_count", VW'(iter_count), VW'(0));
          chk("rst_comp_idx", VW'(comp_idx), VW'(0));
          chk("rst_pulses", VW'({rec_start, conv_start, defl_start, vec_valid, done}), VW'(0));
          b_rec = n_rec;
          @(negedge clk);
          rst = 1'b0;
          repeat (3) @(negedge clk);
          chk("rst_release_idle", VW'({busy, done}), VW'(0));
          chk("rst_no_pulse", VW'(n_rec - b_rec), VW'(0));
          return;
        end
        repeat ($urandom_range(0, 2)) @(negedge clk);
        defl_done = 1'b1;
        @(negedge clk);
        defl_done = 1'b0;
      end
    end
    chk("done", VW'(done), VW'(1));
    chk("busy_done", VW'(busy), VW'(0));
    repeat (3) @(negedge clk);
    chk("done_hold", VW'(done), VW'(1));
    chk("vec_out_hold", vec_out, exp_vout);
    chk("rec_count", VW'(n_rec - b_rec), VW'(exp_rec));
    chk("vec_valid_count", VW'(n_vv - b_vv), VW'(NC));
    chk("defl_count", VW'(n_defl - b_defl), VW'(NC - 1));
  endtask

  initial begin
    #3;
    chk("reset_state", VW'({busy, done, vec_valid, timeout, rec_start, conv_start, defl_start}), VW'(0));
    chk("reset_vec_out", vec_out, '0);
    chk("reset_counts", VW'({comp_idx, iter_count}), VW'(0));
    chk("reset_vectors", rec_vec | defl_vec, '0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    run(0, 2);
    run(0, 1);
    run(1, 0);
    run(2, 1);
    run(0, 0);
    run(3, 0);
    for (int i = 0; i < 10; i++) run(0, 0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
